// File: rtl/comp_block_accum.sv
// Block accumulator: sums N_SAMPLES signed 8-bit samples with per-step saturation, counts negatives.
// Latency: result valid the cycle after the last sample handshake; one or more HOLD cycles per block.
// Backpressure: din_rdy drops while a result is held; the result holds until sum_rdy, then input resumes.
//
// Ports:
//   clk      rising-edge clock
//   res      asynchronous active-low reset
//   din      two's-complement sample, din_vld/din_rdy handshake
//   sum      two's-complement block sum (SUM_W bits)
//   neg_cnt  number of negative samples in the block
//   sat      accumulator clamped at least once in the block
//   sum_vld  result valid, sum_rdy downstream accept
module comp_block_accum #(
   parameter int N_SAMPLES = 8,
   parameter int SUM_W     = 11
) (
   input  logic             clk,
   input  logic             res,
   input  logic [7:0]       din,
   input  logic             din_vld,
   output logic             din_rdy,
   output logic [SUM_W-1:0] sum,
   output logic [8:0]       neg_cnt,
   output logic             sat,
   output logic             sum_vld,
   input  logic             sum_rdy
);

   localparam int CNT_W = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_SAMPLES - 1);
   localparam logic [SUM_W-1:0] SUM_MAX  = {1'b0, {(SUM_W-1){1'b1}}};
   localparam logic [SUM_W-1:0] SUM_MIN  = {1'b1, {(SUM_W-1){1'b0}}};

   typedef enum logic {
      ST_ACC  = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [SUM_W-1:0]  acc_q, acc_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [8:0]        neg_int_q, neg_int_d;
   logic              sat_int_q, sat_int_d;
   logic [SUM_W-1:0]  sum_q, sum_d;
   logic [8:0]        neg_cnt_q, neg_cnt_d;
   logic              sat_q, sat_d;
   logic              sum_vld_q, sum_vld_d;
   logic              din_rdy_q, din_rdy_d;

   // One accumulate step, done one bit wider than the accumulator so that
   // overflow shows up as disagreement between the top two bits.
   logic [SUM_W:0]    din_ext;
   logic [SUM_W:0]    acc_ext;
   logic [SUM_W:0]    nxt;
   logic              ovf;
   logic [SUM_W-1:0]  step_acc;
   logic              step_sat;
   logic [8:0]        step_neg;

   always_comb begin
      din_ext  = {{(SUM_W-7){din[7]}}, din};
      acc_ext  = {acc_q[SUM_W-1], acc_q};
      nxt      = acc_ext + din_ext;
      ovf      = nxt[SUM_W] ^ nxt[SUM_W-1];
      // Sign of the wide result picks the rail to clamp to.
      step_acc = ovf ? (nxt[SUM_W] ? SUM_MIN : SUM_MAX) : nxt[SUM_W-1:0];
      step_sat = sat_int_q | ovf;
      step_neg = neg_int_q + {8'd0, din[7]};
   end

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      neg_int_d = neg_int_q;
      sat_int_d = sat_int_q;
      sum_d     = sum_q;
      neg_cnt_d = neg_cnt_q;
      sat_d     = sat_q;
      sum_vld_d = sum_vld_q;
      din_rdy_d = din_rdy_q;

      case (state_q)
         ST_ACC: begin
            if (din_vld) begin
               if (cnt_q == LAST_CNT) begin
                  // Last sample: publish the step result and start a clean block.
                  sum_d     = step_acc;
                  neg_cnt_d = step_neg;
                  sat_d     = step_sat;
                  acc_d     = '0;
                  cnt_d     = '0;
                  neg_int_d = '0;
                  sat_int_d = 1'b0;
                  sum_vld_d = 1'b1;
                  din_rdy_d = 1'b0;
                  state_d   = ST_HOLD;
               end else begin
                  acc_d     = step_acc;
                  cnt_d     = cnt_q + CNT_W'(1);
                  neg_int_d = step_neg;
                  sat_int_d = step_sat;
               end
            end
         end
         ST_HOLD: begin
            // Result fields keep their values after the handshake; only valid drops.
            if (sum_rdy) begin
               sum_vld_d = 1'b0;
               din_rdy_d = 1'b1;
               state_d   = ST_ACC;
            end
         end
         default: begin
            state_d = ST_ACC;
         end
      endcase
   end

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         state_q   <= ST_ACC;
         acc_q     <= '0;
         cnt_q     <= '0;
         neg_int_q <= '0;
         sat_int_q <= 1'b0;
         sum_q     <= '0;
         neg_cnt_q <= '0;
         sat_q     <= 1'b0;
         sum_vld_q <= 1'b0;
         din_rdy_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         neg_int_q <= neg_int_d;
         sat_int_q <= sat_int_d;
         sum_q     <= sum_d;
         neg_cnt_q <= neg_cnt_d;
         sat_q     <= sat_d;
         sum_vld_q <= sum_vld_d;
         din_rdy_q <= din_rdy_d;
      end
   end

   assign din_rdy = din_rdy_q;
   assign sum     = sum_q;
   assign neg_cnt = neg_cnt_q;
   assign sat     = sat_q;
   assign sum_vld = sum_vld_q;

endmodule

// File: tb/tb_comp_block_accum.sv
// Bench for comp_block_accum: two instances (SUM_W=11 and SUM_W=9) share stimulus.
// Expected results come from an integer model with explicit clamping, queued per block.
// A negedge monitor checks handshakes and pops/compares results as they are presented.
module tb_comp_block_accum;

   localparam int N = 8;

   typedef struct {
      int sum;
      int neg;
      int sat;
   } res_t;

   logic        clk;
   logic        res;
   logic [7:0]  din;
   logic        din_vld;
   logic        sum_rdy;
   int          rdy_mode;   // 0: always ready, 1: random, 2: held low

   logic        din_rdy_w11, din_rdy_w9;
   logic [10:0] sum_w11;
   logic [8:0]  sum_w9;
   logic [8:0]  neg_w11, neg_w9;
   logic        sat_w11, sat_w9;
   logic        sum_vld_w11, sum_vld_w9;

   int n_tests;
   int n_fail;

   // Model state
   res_t q11[$];
   res_t q9[$];
   int   acc11, acc9, sat11, sat9, neg_m, cnt_m;

   comp_block_accum #(.N_SAMPLES(N), .SUM_W(11)) u_dut_w11 (
      .clk(clk), .res(res), .din(din), .din_vld(din_vld), .din_rdy(din_rdy_w11),
      .sum(sum_w11), .neg_cnt(neg_w11), .sat(sat_w11), .sum_vld(sum_vld_w11), .sum_rdy(sum_rdy)
   );

   comp_block_accum #(.N_SAMPLES(N), .SUM_W(9)) u_dut_w9 (
      .clk(clk), .res(res), .din(din), .din_vld(din_vld), .din_rdy(din_rdy_w9),
      .sum(sum_w9), .neg_cnt(neg_w9), .sat(sat_w9), .sum_vld(sum_vld_w9), .sum_rdy(sum_rdy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int clampw(input int v, input int w);
      int hi, lo;
      hi = (1 << (w - 1)) - 1;
      lo = -(1 << (w - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   // sum_rdy driver
   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0: sum_rdy = 1'b1;
         1: sum_rdy = 1'($urandom_range(0, 1));
         default: sum_rdy = 1'b0;
      endcase
   end

   // Monitor / scoreboard: inputs are stable at negedge and describe the next edge.
   always @(negedge clk) begin
      int x, t;
      res_t r;
      if (!res) begin
         q11.delete();
         q9.delete();
         acc11 = 0; acc9 = 0; sat11 = 0; sat9 = 0; neg_m = 0; cnt_m = 0;
         chk("rst_sum_vld_w11", int'(sum_vld_w11), 0);
         chk("rst_din_rdy_w11", int'(din_rdy_w11), 1);
         chk("rst_sum_vld_w9",  int'(sum_vld_w9), 0);
      end else begin
         chk("din_rdy_w11", int'(din_rdy_w11), int'(q11.size() == 0));
         chk("din_rdy_w9",  int'(din_rdy_w9),  int'(q9.size() == 0));
         chk("sum_vld_w11", int'(sum_vld_w11), int'(q11.size() != 0));
         chk("sum_vld_w9",  int'(sum_vld_w9),  int'(q9.size() != 0));
         if (q11.size() != 0) begin
            t = int'($signed(sum_w11));
            chk("sum_w11", t, q11[0].sum);
            chk("neg_w11", int'(neg_w11), q11[0].neg);
            chk("sat_w11", int'(sat_w11), q11[0].sat);
            t = int'($signed(sum_w9));
            chk("sum_w9", t, q9[0].sum);
            chk("neg_w9", int'(neg_w9), q9[0].neg);
            chk("sat_w9", int'(sat_w9), q9[0].sat);
            if (sum_rdy) begin
               void'(q11.pop_front());
               void'(q9.pop_front());
            end
         end else if (din_vld) begin
            x = int'($signed(din));
            t = acc11 + x;
            acc11 = clampw(t, 11);
            if (acc11 != t) sat11 = 1;
            t = acc9 + x;
            acc9 = clampw(t, 9);
            if (acc9 != t) sat9 = 1;
            if (x < 0) neg_m++;
            cnt_m++;
            if (cnt_m == N) begin
               r.sum = acc11; r.neg = neg_m; r.sat = sat11;
               q11.push_back(r);
               r.sum = acc9;  r.sat = sat9;
               q9.push_back(r);
               acc11 = 0; acc9 = 0; sat11 = 0; sat9 = 0; neg_m = 0; cnt_m = 0;
            end
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Present one sample and hold it until the handshake edge, then idle 'gap' cycles.
   task automatic feed(input logic [7:0] v, input int gap);
      bit got;
      got = 1'b0;
      din = v;
      din_vld = 1'b1;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk);
         if (din_rdy_w11) got = 1'b1;
         @(posedge clk);
         #1;
      end
      din_vld = 1'b0;
      if (!got) chk("feed_timeout", 0, 1);
      cyc(gap);
   endtask

   task automatic feed_const(input logic [7:0] v, input int count);
      for (int i = 0; i < count; i++) feed(v, 0);
   endtask

   initial begin
      logic [7:0] sparse_v [8];
      n_tests  = 0;
      n_fail   = 0;
      rdy_mode = 0;
      sum_rdy  = 1'b1;
      din      = 8'h00;
      din_vld  = 1'b0;
      res      = 1'b0;
      cyc(3);
      chk("reset_sum",     int'(sum_w11), 0);
      chk("reset_neg_cnt", int'(neg_w11), 0);
      chk("reset_sat",     int'(sat_w11), 0);
      res = 1'b1;
      cyc(1);

      // Ramp 1..8 back to back
      for (int i = 1; i <= 8; i++) feed(8'(i), 0);
      cyc(2);

      // Negative rail then positive rail, no clamping at 11 bits
      feed_const(8'h80, 8);
      feed_const(8'h7F, 8);
      // Clamp at 9 bits, then a small block must not inherit the flag
      feed_const(8'h7F, 8);
      feed_const(8'h01, 8);
      cyc(2);

      // Backpressure: result held for 10 cycles with input offered
      rdy_mode = 2;
      for (int i = 0; i < 8; i++) feed(8'(i * 3 - 9), 0);
      din = 8'h05;
      din_vld = 1'b1;
      cyc(10);
      rdy_mode = 0;
      feed_const(8'h05, 8);
      cyc(2);

      // Sparse input with alternating signs
      sparse_v = '{8'hFD, 8'h05, 8'hF9, 8'h09, 8'hF5, 8'h0D, 8'hF1, 8'h11};
      for (int i = 0; i < 8; i++) feed(sparse_v[i], 1);
      cyc(2);

      // Reset mid-block discards the partial sum
      feed_const(8'h40, 3);
      res = 1'b0;
      cyc(2);
      res = 1'b1;
      cyc(1);
      feed_const(8'h02, 8);
      cyc(2);

      // Reset while a result is pending clears valid asynchronously
      rdy_mode = 2;
      feed_const(8'hF0, 8);
      cyc(2);
      res = 1'b0;
      #1;
      chk("async_rst_vld_w11", int'(sum_vld_w11), 0);
      chk("async_rst_vld_w9",  int'(sum_vld_w9), 0);
      rdy_mode = 0;
      cyc(2);
      res = 1'b1;
      cyc(2);

      // Randomised blocks with random gaps and random downstream readiness
      rdy_mode = 1;
      for (int b = 0; b < 20; b++) begin
         for (int i = 0; i < 8; i++) feed(8'($urandom_range(0, 255)), int'($urandom_range(0, 2)));
      end
      // Heavily biased random blocks to exercise both rails
      for (int b = 0; b < 6; b++) begin
         for (int i = 0; i < 8; i++) feed(8'((b % 2 == 0) ? $urandom_range(96, 127) : $urandom_range(128, 160)), 0);
      end

      // Drain
      rdy_mode = 0;
      for (int i = 0; i < 100 && q11.size() != 0; i++) cyc(1);
      chk("drain_empty", q11.size(), 0);
      cyc(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
